// File: rtl/max_argmax_pipe.sv
// max_argmax_pipe: pipelined N-input max/min reduction returning the extreme value and its lowest index
module max_argmax_pipe #(
   parameter int N    = 6,
   parameter int W    = 6,
   parameter int IDXW = $clog2(N),
   parameter int L    = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*W-1:0]  in_data,
   input  logic            in_mode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_data,
   output logic [IDXW-1:0] out_idx,
   output logic            out_mode
);
   localparam int P = 1 << L;
   logic            w_adv;
   logic [L-1:0]    w_pv;
   logic [L-1:0]    w_pm;
   logic [L-1:0]    r_vld;
   logic [L-1:0]    r_mode;
   logic [W-1:0]    w_sv [2*P-2];
   logic [IDXW-1:0] w_si [2*P-2];
   logic [W-1:0]    w_nv [P-1];
   logic [IDXW-1:0] w_ni [P-1];
   logic [W-1:0]    r_v  [P-1];
   logic [IDXW-1:0] r_i  [P-1];
   assign w_adv     = !out_valid || out_ready;
   assign in_ready  = w_adv;
   assign w_pv      = L'({r_vld, in_valid});
   assign w_pm      = L'({r_mode, in_mode});
   assign out_valid = r_vld[L-1];
   assign out_mode  = r_mode[L-1];
   assign out_data  = r_v[P-2];
   assign out_idx   = r_i[P-2];
   // leaves (real elements then mode-dependent pads) and registered levels feed each node's two-way pick; left child wins ties
   always_comb begin
      int a;
      int n;
      logic b;
      a = 0;
      n = 0;
      b = 1'b0;
      w_sv = '{default: '0};
      w_si = '{default: '0};
      w_nv = '{default: '0};
      w_ni = '{default: '0};
      for (int k = 0; k < N; k++) begin
         w_sv[k] = in_data[k*W +: W];
         w_si[k] = IDXW'(k);
      end
      for (int k = N; k < P; k++) begin
         w_sv[k] = {W{in_mode}};
         w_si[k] = IDXW'(k);
      end
      for (int k = 0; k < P - 2; k++) begin
         w_sv[P+k] = r_v[k];
         w_si[P+k] = r_i[k];
      end
      for (int s = 0; s < L; s++)
         for (int j = 0; j < (P >> (s + 1)); j++) begin
            a = (2 * P) - ((2 * P) >> s) + 2 * j;
            n = P - (P >> s) + j;
            b = w_pm[s] ? (w_sv[a+1] < w_sv[a]) : (w_sv[a+1] > w_sv[a]);
            w_nv[n] = b ? w_sv[a+1] : w_sv[a];
            w_ni[n] = b ? w_si[a+1] : w_si[a];
         end
   end
   // all levels shift together when the output is free; data loads only behind a valid entry so idle inputs never reach the outputs
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_vld  <= '0;
         r_mode <= '0;
         r_v    <= '{default: '0};
         r_i    <= '{default: '0};
      end else if (w_adv) begin
         r_vld <= w_pv;
         for (int s = 0; s < L; s++)
            if (w_pv[s]) begin
               r_mode[s] <= w_pm[s];
               for (int j = 0; j < (P >> (s + 1)); j++) begin
                  r_v[P - (P >> s) + j] <= w_nv[P - (P >> s) + j];
                  r_i[P - (P >> s) + j] <= w_ni[P - (P >> s) + j];
               end
            end
      end
endmodule

// File: tb/tb_max_argmax_pipe.sv
// tb_max_argmax_pipe: randomized scoreboard bench over several N/W configurations plus directed N=6 scenarios
module tb_max_argmax_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;

   for (genvar c = 0; c < 5; c++) begin : g_c
      localparam int N  = c == 0 ? 6 : c == 1 ? 2 : c == 2 ? 5 : c == 3 ? 8 : 33;
      localparam int W  = c == 0 ? 6 : c == 1 ? 1 : c == 2 ? 16 : c == 3 ? 16 : 1;
      localparam int IW = $clog2(N);
      logic           rst;
      logic           in_valid;
      logic           in_ready;
      logic [N*W-1:0] in_data;
      logic           in_mode;
      logic           out_valid;
      logic           out_ready;
      logic [W-1:0]   out_data;
      logic [IW-1:0]  out_idx;
      logic           out_mode;
      logic           fin = 1'b0;
      logic           held = 1'b0;
      logic [W+IW:0]  hv;
      logic [W+IW:0]  q[$];

      max_argmax_pipe #(.N(N), .W(W)) dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
         .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
         .out_idx(out_idx), .out_mode(out_mode)
      );

      // reference: linear scan, strict improvement only, so the first (lowest) index holding the extreme wins
      function automatic logic [W+IW:0] model(input logic [N*W-1:0] d, input logic m);
         logic [W-1:0] best;
         logic [W-1:0] e;
         int bi;
         best = d[W-1:0];
         bi = 0;
         for (int i = 1; i < N; i++) begin
            e = d[i*W +: W];
            if (m ? (e < best) : (e > best)) begin
               best = e;
               bi = i;
            end
         end
         return {m, IW'(bi), best};
      endfunction

      function automatic logic [W-1:0] rand_elem();
         int r;
         r = int'($urandom % 4);
         return r == 0 ? '0 : r == 1 ? '1 : r == 2 ? W'($urandom % 3) : W'($urandom);
      endfunction

      task automatic fill();
         for (int i = 0; i < N; i++) in_data[i*W +: W] = rand_elem();
      endtask

      task automatic chk(input string nm, input longint got, input longint exp);
         checks++;
         if (got != exp) begin
            errors++;
            $display("FAIL %s cfg%0d got %0d want %0d", nm, c, got, exp);
         end
      endtask

      // scoreboard: every consumed result against the model, plus hold-stability while stalled
      always @(negedge clk) begin
         logic [W+IW:0] e;
         if (rst) begin
            q.delete();
            held = 1'b0;
         end else begin
            if (held) begin
               checks++;
               if ({out_mode, out_idx, out_data} !== hv) begin
                  errors++;
                  $display("FAIL hold cfg%0d got %h want %h", c, {out_mode, out_idx, out_data}, hv);
               end
            end
            held = out_valid && !out_ready;
            hv = {out_mode, out_idx, out_data};
            if (out_valid && out_ready) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected cfg%0d got %h want nothing", c, {out_mode, out_idx, out_data});
               end else begin
                  e = q.pop_front();
                  if ({out_mode, out_idx, out_data} !== e) begin
                     errors++;
                     $display("FAIL result cfg%0d got %h want %h", c, {out_mode, out_idx, out_data}, e);
                  end
               end
            end
            if (in_valid && in_ready) q.push_back(model(in_data, in_mode));
         end
      end

      task automatic drain();
         in_valid = 1'b0;
         out_ready = 1'b1;
         for (int t = 0; t < 40 && (q.size() != 0 || out_valid); t++) begin
            @(posedge clk);
            #1;
         end
         chk("drain_left", q.size(), 0);
      endtask

      task automatic run_one(input logic [35:0] v, input logic m, output int lat);
         in_data = (N*W)'(v);
         in_mode = m;
         in_valid = 1'b1;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_data = 'x;
         for (lat = 1; lat < 20; lat++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
         end
      endtask

      task automatic directed();
         logic [35:0] v0;
         logic [W+IW:0] snap;
         int lat;
         int cnt;
         int first;
         int last;
         v0 = {6'd12, 6'd40, 6'd7, 6'd40, 6'd3, 6'd1};
         run_one(v0, 1'b0, lat);
         chk("max_lat", lat, 3);
         chk("max_data", out_data, 40);
         chk("max_idx", out_idx, 2);
         chk("max_mode", out_mode, 0);
         @(posedge clk); #1;
         run_one(v0, 1'b1, lat);
         chk("min_data", out_data, 1);
         chk("min_idx", out_idx, 0);
         chk("min_mode", out_mode, 1);
         @(posedge clk); #1;
         run_one(36'hF_FFFF_FFFF, 1'b1, lat);
         chk("all63_data", out_data, 63);
         chk("all63_idx", out_idx, 0);
         @(posedge clk); #1;
         cnt = 0;
         first = -1;
         last = -1;
         fork
            begin
               for (int i = 0; i < 8; i++) begin
                  fill();
                  in_mode = 1'(i % 2);
                  in_valid = 1'b1;
                  @(posedge clk);
                  #1;
               end
               in_valid = 1'b0;
            end
            begin
               for (int t = 0; t < 16; t++) begin
                  @(negedge clk);
                  if (out_valid) begin
                     if (first < 0) first = t;
                     last = t;
                     cnt++;
                  end
               end
            end
         join
         chk("b2b_count", cnt, 8);
         chk("b2b_span", last - first + 1, 8);
         @(posedge clk); #1;
         out_ready = 1'b0;
         in_valid = 1'b1;
         for (int i = 0; i < 10; i++) begin
            fill();
            in_mode = 1'($urandom % 2);
            @(negedge clk);
            if (!in_ready) break;
            @(posedge clk);
            #1;
         end
         snap = {out_mode, out_idx, out_data};
         for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_ready", in_ready, 0);
            chk("stall_hold", {out_mode, out_idx, out_data}, snap);
         end
         @(posedge clk); #1;
         out_ready = 1'b1;
         for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            fill();
            in_mode = 1'($urandom % 2);
         end
         drain();
         out_ready = 1'b0;
         for (int i = 0; i < 3; i++) begin
            fill();
            in_mode = 1'(i % 2);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b0;
         #2;
         rst = 1'b1;
         #1;
         chk("rst_valid", out_valid, 0);
         chk("rst_ready", in_ready, 1);
         chk("rst_data", out_data, 0);
         @(posedge clk);
         #3;
         rst = 1'b0;
         out_ready = 1'b1;
         cnt = 0;
         for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (out_valid) cnt++;
         end
         chk("stale_after_rst", cnt, 0);
         @(posedge clk); #1;
         run_one(v0, 1'b0, lat);
         chk("rst_lat", lat, 3);
         chk("rst_data_after", out_data, 40);
         @(posedge clk); #1;
      endtask

      task automatic rand_phase(input int nv);
         int n;
         n = 0;
         while (n < nv) begin
            in_valid = ($urandom % 4) != 0;
            in_mode = 1'($urandom % 2);
            fill();
            if (!in_valid) in_data = 'x;
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            if (in_valid && in_ready) n++;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
      endtask

      initial begin
         rst = 1'b1;
         in_valid = 1'b0;
         in_mode = 1'b0;
         in_data = '0;
         out_ready = 1'b0;
         #12;
         chk("reset_valid", out_valid, 0);
         chk("reset_data", out_data, 0);
         chk("reset_idx", out_idx, 0);
         chk("reset_mode", out_mode, 0);
         chk("reset_ready", in_ready, 1);
         @(posedge clk);
         #3;
         rst = 1'b0;
         @(posedge clk);
         #1;
         out_ready = 1'b1;
         if (c == 0) directed();
         rand_phase(10000);
         drain();
         fin = 1'b1;
      end
   end

   initial begin
      bit done;
      done = 1'b0;
      for (int t = 0; t < 80000 && !done; t++) begin
         @(posedge clk);
         done = g_c[0].fin && g_c[1].fin && g_c[2].fin && g_c[3].fin && g_c[4].fin;
      end
      if (!done) begin
         errors++;
         $display("FAIL timeout got unfinished want all configurations finished");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
